// File: rtl/pic_wr_pkg.sv
// Shared encodings for the UART-to-image-RAM writer: FSM states, header bytes, address width.
package pic_wr_pkg;
  localparam int ADDR_W = 14;
  localparam logic [7:0] HDR_B0 = 8'hA5;
  localparam logic [7:0] HDR_B1 = 8'h5A;

  typedef enum logic [1:0] {
    ST_HDR0,
    ST_HDR1,
    ST_HI,
    ST_LO
  } wr_st_e;
endpackage

// File: rtl/uart_pic_wr_if.sv
// Byte-in / pixel-write-out bundle of uart_pic_wr; master drives bytes, slave is the writer.
interface uart_pic_wr_if;
  import pic_wr_pkg::*;
  logic              pi_flag;
  logic [7:0]        pi_data;
  logic              frame_clr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              frame_done;
  logic              busy;

  modport master (output pi_flag, pi_data, frame_clr,
                  input  wr_en, wr_addr, wr_data, frame_done, busy);
  modport slave  (input  pi_flag, pi_data, frame_clr,
                  output wr_en, wr_addr, wr_data, frame_done, busy);
endinterface

// File: rtl/pic_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while run is high, pulses expire at TIMEOUT_CYC-1.
module pic_gap_timer #(
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic run,
  output logic expire
);
  localparam logic [19:0] TMAX = 20'(TIMEOUT_CYC - 1);

  logic [19:0] cnt_q;

  // A byte arriving on the expiry cycle restarts the gap instead of dropping it.
  assign expire = run && !clr && (cnt_q == TMAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)             cnt_q <= '0;
    else if (clr || !run || expire) cnt_q <= '0;
    else                        cnt_q <= cnt_q + 20'd1;
  end
endmodule

// File: rtl/uart_pic_wr.sv
// Assembles RGB565 pixels (high byte first) from a UART byte stream into the image RAM.
// Optional frame header A5 5A before each frame when PIC_HDR_SYNC_EN is defined.
module uart_pic_wr
  import pic_wr_pkg::*;
#(
  parameter int IMAGE_SIZE  = 10000,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  uart_pic_wr_if.slave  bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_SIZE - 1);
`ifdef PIC_HDR_SYNC_EN
  localparam wr_st_e ST_FIRST = ST_HDR0;
`else
  localparam wr_st_e ST_FIRST = ST_HI;
`endif

  wr_st_e            st_q, st_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        hi_q;
  logic              fire, expire, last;
  logic              wr_en_q, frame_done_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [15:0]       wr_data_q;

  assign last = (addr_q == LAST_ADDR);
  assign fire = bus.pi_flag && !bus.frame_clr && (st_q == ST_LO);

  pic_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (bus.pi_flag | bus.frame_clr),
    .run       (st_q != ST_FIRST),
    .expire    (expire)
  );

  always_comb begin
    st_d = st_q;
    if (bus.pi_flag) begin
      case (st_q)
        ST_HDR0: if (bus.pi_data == HDR_B0) st_d = ST_HDR1;
        ST_HDR1: begin
          if (bus.pi_data == HDR_B1)      st_d = ST_HI;
          else if (bus.pi_data != HDR_B0) st_d = ST_HDR0;
        end
        ST_HI:   st_d = ST_LO;
        ST_LO:   st_d = last ? ST_FIRST : ST_HI;
        default: st_d = ST_FIRST;
      endcase
    end
    if (expire)        st_d = ST_FIRST;
    if (bus.frame_clr) st_d = ST_FIRST;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) st_q <= ST_FIRST;
    else            st_q <= st_d;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      addr_q       <= '0;
      hi_q         <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      wr_en_q      <= fire;
      frame_done_q <= fire && last;
      if (bus.pi_flag && !bus.frame_clr && st_q == ST_HI) hi_q <= bus.pi_data;
      if (fire) begin
        wr_addr_q <= addr_q;
        wr_data_q <= {hi_q, bus.pi_data};
      end
      if (bus.frame_clr) addr_q <= '0;
      else if (fire)     addr_q <= last ? '0 : addr_q + 1'b1;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (addr_q != '0) || (st_q == ST_LO);
endmodule

// File: tb/tb_uart_pic_wr.sv
// Directed bench for uart_pic_wr: two instances (4-pixel and 10000-pixel frames) on one byte stream.
module tb_uart_pic_wr;
  import pic_wr_pkg::*;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       pi_flag   = 1'b0;
  logic [7:0] pi_data   = 8'h00;
  logic       frame_clr = 1'b0;

  always #5 sys_clk = ~sys_clk;

  uart_pic_wr_if ia();
  uart_pic_wr_if ib();
  assign ia.pi_flag = pi_flag;  assign ia.pi_data = pi_data;  assign ia.frame_clr = frame_clr;
  assign ib.pi_flag = pi_flag;  assign ib.pi_data = pi_data;  assign ib.frame_clr = frame_clr;

  uart_pic_wr #(.IMAGE_SIZE(4),     .TIMEOUT_CYC(16)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(ia));
  uart_pic_wr #(.IMAGE_SIZE(10000), .TIMEOUT_CYC(16)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(ib));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // write logs {addr, data}, sampled on the falling edge
  logic [29:0] wa[$];
  logic [29:0] wb[$];
  int          fda = 0, fdb = 0;
  logic [13:0] fd_addr_a = '0;
  logic        fd_busy_a = 1'b1;

  always @(negedge sys_clk) begin
    if (ia.wr_en) wa.push_back({ia.wr_addr, ia.wr_data});
    if (ib.wr_en) wb.push_back({ib.wr_addr, ib.wr_data});
    if (ia.frame_done) begin
      fda++;
      fd_addr_a = ia.wr_addr;
      fd_busy_a = ia.busy;
    end
    if (ib.frame_done) fdb++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    pi_flag = 1'b1;
    pi_data = b;
    tick(1);
    pi_flag = 1'b0;
  endtask

  task automatic clr_log();
    wa.delete(); wb.delete(); fda = 0; fdb = 0;
  endtask

  task automatic do_reset();
    #2 sys_rst_n = 1'b0;
    tick(2);
    sys_rst_n = 1'b1;
    tick(1);
    clr_log();
  endtask

  initial begin
    tick(2);
    // 1: reset state
    chk("rst_en_a",   32'(ia.wr_en),      0);
    chk("rst_addr_a", 32'(ia.wr_addr),    0);
    chk("rst_data_a", 32'(ia.wr_data),    0);
    chk("rst_fd_a",   32'(ia.frame_done), 0);
    chk("rst_busy_a", 32'(ia.busy),       0);
    chk("rst_en_b",   32'(ib.wr_en),      0);
    chk("rst_busy_b", 32'(ib.busy),       0);
    sys_rst_n = 1'b1;
    tick(1);
    clr_log();

`ifndef PIC_HDR_SYNC_EN
    // 2: single pixel, registered write one cycle after the low byte
    send(8'hF8);
    chk("t2_busy_hi", 32'(ib.busy), 1);
    send(8'h00);
    chk("t2_en",   32'(ib.wr_en),   1);
    chk("t2_addr", 32'(ib.wr_addr), 0);
    chk("t2_data", 32'(ib.wr_data), 32'hF800);
    tick(1);
    chk("t2_en_off", 32'(ib.wr_en),   0);
    chk("t2_hold",   32'(ib.wr_data), 32'hF800);
    chk("t2_cnt",    32'(wb.size()),  1);

    // 3: back-to-back bytes, wrap at 4 on dut_a
    do_reset();
    for (int i = 0; i < 10; i++) send(8'(8'h10 + i));
    tick(2);
    chk("t3_cnt_a", 32'(wa.size()), 5);
    chk("t3_cnt_b", 32'(wb.size()), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < wa.size())
        chk($sformatf("t3_a%0d", k), 32'(wa[k]),
            32'({14'(k % 4), 8'(8'h10 + 2*k), 8'(8'h11 + 2*k)}));
      if (k < wb.size())
        chk($sformatf("t3_b%0d", k), 32'(wb[k]),
            32'({14'(k), 8'(8'h10 + 2*k), 8'(8'h11 + 2*k)}));
    end
    chk("t3_fd_a",      32'(fda),       1);
    chk("t3_fd_addr",   32'(fd_addr_a), 3);
    chk("t3_fd_busy",   32'(fd_busy_a), 0);
    chk("t3_fd_b",      32'(fdb),       0);

    // 4: partial pixel dropped after gap timeout
    do_reset();
    send(8'h12);
    tick(20);
    chk("t4_busy_idle", 32'(ia.busy), 0);
    send(8'h34);
    send(8'h56);
    tick(2);
    chk("t4_cnt", 32'(wa.size()), 1);
    if (wa.size() > 0) chk("t4_wr", 32'(wa[0]), 32'({14'd0, 16'h3456}));

    // 5: frame_clr collides with the low byte at addr 5
    do_reset();
    for (int i = 0; i < 10; i++) send(8'(i));
    send(8'hAA);
    chk("t5_busy_pre", 32'(ib.busy), 1);
    clr_log();
    pi_flag = 1'b1; pi_data = 8'hBB; frame_clr = 1'b1;
    tick(1);
    pi_flag = 1'b0; frame_clr = 1'b0;
    chk("t5_no_wr_b", 32'(ib.wr_en), 0);
    chk("t5_no_wr_a", 32'(ia.wr_en), 0);
    chk("t5_busy_b",  32'(ib.busy),  0);
    send(8'hCC);
    send(8'hDD);
    tick(1);
    chk("t5_cnt_b", 32'(wb.size()), 1);
    if (wb.size() > 0) chk("t5_wr_b", 32'(wb[0]), 32'({14'd0, 16'hCCDD}));
    if (wa.size() > 0) chk("t5_wr_a", 32'(wa[0]), 32'({14'd0, 16'hCCDD}));

    // 6 (raw build): no header, stream is pixels from reset
    do_reset();
    send(8'h07);
    send(8'hE0);
    tick(1);
    chk("t6_cnt", 32'(wb.size()), 1);
    if (wb.size() > 0) chk("t6_wr", 32'(wb[0]), 32'({14'd0, 16'h07E0}));
`else
    // 6: header A5 A5 5A then one pixel
    send(8'hA5); send(8'hA5); send(8'h5A); send(8'h07); send(8'hE0);
    tick(1);
    chk("t6_cnt", 32'(wb.size()), 1);
    if (wb.size() > 0) chk("t6_wr", 32'(wb[0]), 32'({14'd0, 16'h07E0}));
    do_reset();
    send(8'h07); send(8'hE0);
    tick(2);
    chk("t6_nohdr", 32'(wb.size()), 0);
    chk("t6_nohdr_busy", 32'(ib.busy), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
